// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and constant helpers shared by the UART receiver and transmitter.
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // One spare bit so a counter can hold its terminal count without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchroniser for an asynchronous input that idles high.
module uart_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= sync_d;

  assign q = sync_q[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 1-start / DATA_BITS / 1-stop serial receiver, LSB first, sampled mid-bit.
// A low stop bit flags a framing error and parks in BREAK until the line returns high.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int DATA_BITS = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);
  localparam int CPB      = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT = CPB / 2;
  localparam int CW       = cnt_width(CPB);
  localparam int BW       = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] CPB_M1   = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rx_s;
  logic                 half_tick, bit_tick, stop_sample;

  uart_sync_2ff u_sync (
    .clk  (PCLK),
    .rst_n(PRESETn),
    .d    (rx_serial),
    .q    (rx_s)
  );

  always_comb begin
    half_tick   = (state_q == ST_START) && (clk_cnt_q == HALF_M1);
    bit_tick    = (state_q == ST_DATA || state_q == ST_STOP) && (clk_cnt_q == CPB_M1);
    stop_sample = (state_q == ST_STOP) && bit_tick;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx_s) state_d = ST_START;
      ST_START: if (half_tick) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_tick && bit_cnt_q == LAST_BIT) state_d = ST_STOP;
      ST_STOP:  if (bit_tick) state_d = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters restart at every phase boundary; IDLE and BREAK keep them parked at zero.
  always_comb begin
    clk_cnt_d = (state_q == ST_IDLE || state_q == ST_BREAK || half_tick || bit_tick)
                ? '0 : clk_cnt_q + 1'b1;
    bit_cnt_d = (state_q != ST_DATA) ? '0 : bit_cnt_q + BW'(bit_tick);
    shift_d   = (state_q == ST_DATA && bit_tick) ? {rx_s, shift_q[DATA_BITS-1:1]} : shift_q;
    rx_data_d = (stop_sample && rx_s) ? shift_q : rx_data_q;
    done_d    = stop_sample && rx_s;
    err_d     = stop_sample && !rx_s;
  end

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      rx_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end

  assign rx_data      = rx_data_q;
  assign rx_done      = done_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized frames checked by a queue scoreboard fed from a frame-level model.
module tb_uart_receiver;
  localparam int BAUD = 1_000_000;
  localparam int CLKF = 16_000_000;
  localparam int DB   = 8;
  localparam int CPB  = CLKF / BAUD;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + (DB + 1) * CPB;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         edge_n;
  } exp_t;

  logic       PCLK = 0;
  logic       PRESETn = 0;
  logic       rx_serial = 1;
  logic [7:0] rx_data;
  logic       rx_done, rx_frame_err, rx_busy;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  exp_t       sb[$];
  exp_t       got;
  logic [7:0] model_data = 8'h00;
  logic       prev_evt = 0;

  uart_receiver #(.BAUD_RATE(BAUD), .CLK_FREQ(CLKF), .DATA_BITS(DB)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .rx_serial   (rx_serial),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge PCLK) begin
    if (rx_done || rx_frame_err) begin
      chk("exclusive", {31'd0, rx_done & rx_frame_err}, 0);
      if (prev_evt) chk("pulse_width", 1, 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event done=%0b err=%0b data=%0h at cycle %0d", rx_done, rx_frame_err, rx_data, cyc);
      end else begin
        got = sb.pop_front();
        chk("event_kind", {31'd0, rx_frame_err}, {31'd0, got.err});
        chk("rx_data", {24'd0, rx_data}, {24'd0, got.data});
        if (got.edge_n >= 0) chk("event_edge", cyc, got.edge_n);
        if (rx_done) chk("busy_fall", {31'd0, rx_busy}, 0);
      end
    end
    prev_evt <= rx_done | rx_frame_err;
  end

  // Called aligned 1 time unit after a posedge; holds the line for n sampling edges.
  task automatic drive(input logic v, input int n);
    rx_serial = v;
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int p);
    exp_t e;
    e.err    = !stop;
    e.data   = stop ? d : model_data;
    e.edge_n = (p == CPB) ? cyc + 1 + LAT : -1;
    sb.push_back(e);
    if (stop) model_data = d;
    drive(0, p);
    for (int k = 0; k < DB; k++) drive(d[k], p);
    drive(stop, p);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, {24'd0, rx_data}, 0);
    chk({tag, "_done"}, {31'd0, rx_done}, 0);
    chk({tag, "_err"}, {31'd0, rx_frame_err}, 0);
    chk({tag, "_busy"}, {31'd0, rx_busy}, 0);
  endtask

  initial begin
    logic [7:0] f0 = 8'hF0;
    repeat (3) @(posedge PCLK);
    #1;
    chk_reset_outputs("reset");
    PRESETn = 1;
    drive(1, 20);

    send_frame(8'h55, 1, CPB);
    drive(1, 20);
    send_frame(8'hA5, 1, CPB);
    send_frame(8'h3C, 1, CPB);
    drive(1, 20);

    rx_serial = 0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("glitch_busy_rise", {31'd0, rx_busy}, 1);
    repeat (2) @(posedge PCLK);
    #1;
    rx_serial = 1;
    repeat (6) @(posedge PCLK);
    @(negedge PCLK);
    chk("glitch_busy_fall", {31'd0, rx_busy}, 0);
    @(posedge PCLK);
    #1;
    drive(1, 20);

    send_frame(8'h99, 0, CPB);
    drive(0, 400);
    chk("break_busy", {31'd0, rx_busy}, 1);
    drive(1, 20);
    chk("break_exit", {31'd0, rx_busy}, 0);
    send_frame(8'($urandom_range(1, 255)), 1, CPB);
    drive(1, 20);

    drive(0, CPB);
    for (int k = 0; k < 4; k++) drive(f0[k], CPB);
    drive(f0[4], HALF);
    PRESETn = 0;
    #1;
    chk_reset_outputs("async_reset");
    rx_serial = 1;
    model_data = 8'h00;
    repeat (3) @(posedge PCLK);
    #1;
    PRESETn = 1;
    drive(1, 20);
    send_frame(8'h0F, 1, CPB);
    drive(1, 20);

    send_frame(8'hC3, 1, 15);
    drive(1, 20);
    send_frame(8'hC3, 1, 17);
    drive(1, 20);

    for (int i = 0; i < 8; i++) begin
      send_frame(8'($urandom), 1, CPB);
      drive(1, $urandom_range(1, 20));
    end

    for (int i = 0; i < 500 && sb.size() > 0; i++) @(posedge PCLK);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver; the receive half of the APB UART IP, and the counterpart of the UART transmitter on the same serial line. It synchronises the asynchronous `rx_serial` line and detects and validates the start bit. It samples `DATA_BITS` data bits LSB-first at mid-bit, then checks the stop bit and presents the byte to the APB register block with a one-cycle strobe. Frame format: 1 start (low), `DATA_BITS` data, 1 stop (high), no parity.

## Interface
- `BAUD_RATE`, 9600, line rate in bit/s
- `CLK_FREQ`, 100_000_000, PCLK frequency in Hz
- `DATA_BITS`, 8, data bits per frame

- `PCLK`  in  1  system clock (one clock domain)
- `PRESETn`  in  1  asynchronous active-low reset
- `rx_serial`  in  1  asynchronous serial RX line; idles high
- `rx_data`  out  DATA_BITS  last correctly framed word; held until the next good frame
- `rx_done`  out  1  one-cycle pulse; `rx_data` is updated in the same cycle
- `rx_frame_err`  out  1  one-cycle pulse; stop bit sampled low
- `rx_busy`  out  1  high whenever state ≠ IDLE

## Operation
- Derived constants:
  - CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division).
  - HALF_BIT = CLKS_PER_BIT / 2.
  - Clock counter width = $clog2(CLKS_PER_BIT)+1.
  - Bit counter width = $clog2(DATA_BITS)+1.
- Input synchroniser: 2 flops, both reset to 1. Only the second flop output (`rx_s`) is used.
- FSM states and transitions:
  - **IDLE**: clock and bit counters held at 0. `rx_s`==0 → START.
  - **START**: clock counter counts 0..HALF_BIT-1. At HALF_BIT-1, if `rx_s`==0 → DATA with counter cleared. Otherwise → IDLE, a glitch, with no error flagged.
  - **DATA**: clock counter counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, shift `rx_s` into the shift register at the MSB so that bit 0 ends up at the LSB, increment the bit counter and clear the clock counter. After the DATA_BITS-th sample → STOP.
  - **STOP**: at clock counter CLKS_PER_BIT-1, sample `rx_s`.
    - If 1: `rx_data` <= shift register, pulse `rx_done`, → IDLE.
    - If 0: pulse `rx_frame_err`, leave `rx_data` unchanged, → BREAK.
  - **BREAK**: wait for `rx_s`==1, then → IDLE. This keeps a held-low line (break) from being re-detected as a start bit.
- Return to IDLE happens mid-stop-bit, so back-to-back frames with a single stop bit are received without loss.
- No overrun detection; the consumer must read `rx_data` before the next `rx_done`.

## Timing
- Reset values:
  - `rx_data`=0, `rx_done`=0, `rx_frame_err`=0, `rx_busy`=0.
  - state=IDLE, both counters=0, shift register=0, synchroniser=1.
- Reset mid-frame aborts immediately. No `rx_done` or `rx_frame_err` is produced for the partial frame.
- Latency: number PCLK edges from edge 0, the first edge that samples `rx_serial` low.
  - State enters START at edge 2.
  - Start validation at edge 2+HALF_BIT.
  - Data bit k is sampled at edge 2+HALF_BIT+(k+1)·CLKS_PER_BIT.
  - `rx_done` or `rx_frame_err` is registered high at edge 2+HALF_BIT+(DATA_BITS+1)·CLKS_PER_BIT, for exactly one cycle.
- `rx_busy` rises 1 cycle after the synchroniser shows low. It falls in the same cycle `rx_done` rises.
- `rx_done` and `rx_frame_err` are mutually exclusive.
- Sampling-point tolerance is ±HALF_BIT; baud mismatch under ~4% over 10 bits is required to work.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding, common with the transmitter, plus the BREAK code.
  - Helper functions for CLKS_PER_BIT and the counter widths.
- Sub-module `uart_sync_2ff`: reset-to-1 two-flop synchroniser, reusable for CTS-style inputs.
- Everything else lives in one module:
  - next-state and output logic in separate always blocks;
  - counters and shift register in registered blocks with async reset.

## Test plan
Bench parameters: BAUD_RATE=1_000_000, CLK_FREQ=16_000_000, giving CLKS_PER_BIT=16 and HALF_BIT=8.
- Frame 0x55 driven at 16 cycles/bit → one `rx_done` exactly 154 edges after the falling start edge; `rx_data`=0x55; `rx_frame_err` never high.
- Frames 0xA5 and 0x3C back-to-back, 1 stop bit each → two `rx_done` pulses 160 cycles apart; `rx_data` reads 0xA5 then 0x3C.
- 5-cycle low glitch on an idle line → no `rx_done`, no `rx_frame_err`; `rx_busy` returns low within 11 cycles.
- Frame 0x99 with the stop bit driven low and the line then held low for 400 cycles → one `rx_frame_err`; `rx_data` keeps its previous value; no new frame until the line goes high and a fresh start bit arrives.
- `PRESETn` asserted during data bit 4 of 0xF0 → outputs return to reset values asynchronously; a following frame 0x0F is received correctly.
- Bit period skewed to 15 and to 17 cycles with 0xC3 → `rx_data`=0xC3, no error.
